mux2_arbiter: RTL

Two-requester round-robin arbiter that owns a shared 2:1 data mux. Each requester raises a request. The block grants the shared path to one requester at a time, drives the mux select, and forwards the granted data to the single output. A hold limit bounds how long one requester keeps the path while the other waits. It sits in front of any resource with two sources and one sink.

---
 rtl/mux2_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester round-robin arbiter that owns a shared 2:1 data mux.
// One requester at a time is granted the path. Its data is forwarded to y, and a
// hold limit bounds how long a grant may last while the other source is waiting.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req0, req1   level requests, held for the whole burst
//   d0, d1       source data
//   gnt0, gnt1   grants, decoded directly from the state register (never both high)
//   sel          mux select, equal to gnt1
//   y            sel ? d1 : d0, combinational from the data inputs
//   y_valid      gnt0 | gnt1
module mux2_arbiter #(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid
);

   localparam int unsigned HCNT_W = $clog2(MAX_HOLD) + 1;
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

   state_e              state_q;
   logic                last_q;    // source granted most recently
   logic [HCNT_W-1:0]   hcnt_q;    // cycles held since grant entry, saturating
   logic                hold_done;

   // The current holder has used its full share once hcnt reaches MAX_HOLD-1
   assign hold_done = (hcnt_q == HOLD_LAST);

   // Grant FSM, priority pointer and hold counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         hcnt_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // On a tie the source that was not granted last wins
               if (req0 && (!req1 || last_q)) begin
                  state_q <= GNT0;
                  last_q  <= 1'b0;
                  hcnt_q  <= '0;
               end else if (req1) begin
                  state_q <= GNT1;
                  last_q  <= 1'b1;
                  hcnt_q  <= '0;
               end
            end
            GNT0: begin
               // Hand over on release, or preempt once the hold budget is spent
               if (req1 && (!req0 || hold_done)) begin
                  state_q <= GNT1;
                  last_q  <= 1'b1;
                  hcnt_q  <= '0;
               end else if (!req0) begin
                  state_q <= IDLE;
               end else if (!hold_done) begin
                  hcnt_q <= hcnt_q + HCNT_W'(1);
               end
            end
            GNT1: begin
               if (req0 && (!req1 || hold_done)) begin
                  state_q <= GNT0;
                  last_q  <= 1'b0;
                  hcnt_q  <= '0;
               end else if (!req1) begin
                  state_q <= IDLE;
               end else if (!hold_done) begin
                  hcnt_q <= hcnt_q + HCNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Grant decode and shared data path
   assign gnt0    = (state_q == GNT0);
   assign gnt1    = (state_q == GNT1);
   assign sel     = gnt1;
   assign y_valid = gnt0 | gnt1;
   assign y       = sel ? d1 : d0;

endmodule
